// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode results each edge, or a zero bubble on stall/flush.
// Optional PERF_CNT_EN adds saturating bubble/flush event counters.
module id_ex_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              IDvalid,
  input  logic [4:0]        IDrs,
  input  logic [4:0]        IDrt,
  input  logic [4:0]        IDrd,
  input  logic [DATA_W-1:0] IDrsData,
  input  logic [DATA_W-1:0] IDrtData,
  input  logic [DATA_W-1:0] IDimm,
  input  logic [DATA_W-1:0] IDpc4,
  input  logic              IDRegWrite,
  input  logic              IDMemRead,
  input  logic              IDMemWrite,
  input  logic              IDALUSrc,
  input  logic [1:0]        IDMemtoReg,
  input  logic [1:0]        IDRegDst,
  input  logic [3:0]        IDALUOp,
  output logic              EXvalid,
  output logic [4:0]        EXrs,
  output logic [4:0]        EXrt,
  output logic [4:0]        EXrd,
  output logic [DATA_W-1:0] EXrsData,
  output logic [DATA_W-1:0] EXrtData,
  output logic [DATA_W-1:0] EXimm,
  output logic [DATA_W-1:0] EXpc4,
  output logic              EXRegWrite,
  output logic              EXMemRead,
  output logic              EXMemWrite,
  output logic              EXALUSrc,
  output logic [1:0]        EXMemtoReg,
  output logic [1:0]        EXRegDst,
  output logic [3:0]        EXALUOp
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       BubbleCnt,
  output logic [31:0]       FlushCnt
`endif
);

  logic              bubble_p0;
  logic              vld_p1;
  logic [4:0]        rs_p1, rt_p1, rd_p1;
  logic [DATA_W-1:0] rs_data_p1, rt_data_p1, imm_p1, pc4_p1;
  logic              reg_write_p1, mem_read_p1, mem_write_p1, alu_src_p1;
  logic [1:0]        mem_to_reg_p1, reg_dst_p1;
  logic [3:0]        alu_op_p1;

  assign bubble_p0 = stall | flush;

  // ID -> EX boundary: every edge loads either ID contents or an all-zero bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble_p0) begin
      vld_p1        <= 1'b0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      pc4_p1        <= '0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      alu_src_p1    <= 1'b0;
      mem_to_reg_p1 <= '0;
      reg_dst_p1    <= '0;
      alu_op_p1     <= '0;
    end else begin
      vld_p1        <= IDvalid;
      rs_p1         <= IDrs;
      rt_p1         <= IDrt;
      rd_p1         <= IDrd;
      rs_data_p1    <= IDrsData;
      rt_data_p1    <= IDrtData;
      imm_p1        <= IDimm;
      pc4_p1        <= IDpc4;
      reg_write_p1  <= IDRegWrite;
      mem_read_p1   <= IDMemRead;
      mem_write_p1  <= IDMemWrite;
      alu_src_p1    <= IDALUSrc;
      mem_to_reg_p1 <= IDMemtoReg;
      reg_dst_p1    <= IDRegDst;
      alu_op_p1     <= IDALUOp;
    end
  end

  // Outputs come straight from flops so the hazard unit never sees a loop through stall
  assign EXvalid    = vld_p1;
  assign EXrs       = rs_p1;
  assign EXrt       = rt_p1;
  assign EXrd       = rd_p1;
  assign EXrsData   = rs_data_p1;
  assign EXrtData   = rt_data_p1;
  assign EXimm      = imm_p1;
  assign EXpc4      = pc4_p1;
  assign EXRegWrite = reg_write_p1;
  assign EXMemRead  = mem_read_p1;
  assign EXMemWrite = mem_write_p1;
  assign EXALUSrc   = alu_src_p1;
  assign EXMemtoReg = mem_to_reg_p1;
  assign EXRegDst   = reg_dst_p1;
  assign EXALUOp    = alu_op_p1;

`ifdef PERF_CNT_EN
  logic [31:0] bubble_cnt_p1, flush_cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Flush takes precedence: a combined request counts only as a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_p1 <= '0;
      flush_cnt_p1  <= '0;
    end else if (flush) begin
      flush_cnt_p1  <= sat_inc(flush_cnt_p1);
    end else if (stall) begin
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign BubbleCnt = bubble_cnt_p1;
  assign FlushCnt  = flush_cnt_p1;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: driver queues expected EX contents, monitor compares after each edge.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm, pc4;
    logic        rw, mr, mw, as;
    logic [1:0]  m2r, rdst;
    logic [3:0]  op;
  } bundle_t;

  typedef struct {
    string       name;
    bundle_t     v;
    logic [31:0] bc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, stall, flush;
  bundle_t id_in, ex_out;
  logic [31:0] bubble_cnt, flush_cnt;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] bc_exp = 0;
  logic [31:0] fc_exp = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .IDvalid(id_in.valid), .IDrs(id_in.rs), .IDrt(id_in.rt), .IDrd(id_in.rd),
    .IDrsData(id_in.rsd), .IDrtData(id_in.rtd), .IDimm(id_in.imm), .IDpc4(id_in.pc4),
    .IDRegWrite(id_in.rw), .IDMemRead(id_in.mr), .IDMemWrite(id_in.mw), .IDALUSrc(id_in.as),
    .IDMemtoReg(id_in.m2r), .IDRegDst(id_in.rdst), .IDALUOp(id_in.op),
    .EXvalid(ex_out.valid), .EXrs(ex_out.rs), .EXrt(ex_out.rt), .EXrd(ex_out.rd),
    .EXrsData(ex_out.rsd), .EXrtData(ex_out.rtd), .EXimm(ex_out.imm), .EXpc4(ex_out.pc4),
    .EXRegWrite(ex_out.rw), .EXMemRead(ex_out.mr), .EXMemWrite(ex_out.mw), .EXALUSrc(ex_out.as),
    .EXMemtoReg(ex_out.m2r), .EXRegDst(ex_out.rdst), .EXALUOp(ex_out.op)
`ifdef PERF_CNT_EN
    , .BubbleCnt(bubble_cnt), .FlushCnt(flush_cnt)
`endif
  );

`ifndef PERF_CNT_EN
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

  function automatic logic [31:0] sat1(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  task automatic check_vec(input string name, input bundle_t act, input bundle_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check_cnt(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Drive one edge worth of stimulus and queue what EX must show after that edge
  task automatic step(input string name, input logic s, input logic f, input bundle_t b);
    exp_t e;
    @(negedge clk);
    stall = s;
    flush = f;
    id_in = b;
    e.name = name;
    e.v    = (s || f) ? '0 : b;
    if (f) fc_exp = sat1(fc_exp);
    else if (s) bc_exp = sat1(bc_exp);
    e.bc = bc_exp;
    e.fc = fc_exp;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_vec(e.name, ex_out, e.v);
`ifdef PERF_CNT_EN
      check_cnt({e.name, "_bcnt"}, bubble_cnt, e.bc);
      check_cnt({e.name, "_fcnt"}, flush_cnt, e.fc);
`endif
    end
  end

  bundle_t z, pt, ld, other, inv, ones, post;

  initial begin
    z = '0;
    pt = '0;
    pt.valid = 1'b1; pt.rs = 5'd5; pt.rt = 5'd6; pt.rd = 5'd7;
    pt.rsd = 32'h1234_5678; pt.rw = 1'b1; pt.op = 4'h2;
    ld = '0;
    ld.valid = 1'b1; ld.mr = 1'b1; ld.rt = 5'd8; ld.rs = 5'd3; ld.imm = 32'h0000_0010;
    ld.rw = 1'b1; ld.m2r = 2'd1; ld.as = 1'b1; ld.pc4 = 32'h0000_0104;
    other = '0;
    other.valid = 1'b1; other.rs = 5'd8; other.rt = 5'd9; other.rd = 5'd10;
    other.rsd = 32'hDEAD_BEEF; other.rtd = 32'hCAFE_F00D; other.rw = 1'b1; other.rdst = 2'd1; other.op = 4'h6;
    inv = '0;
    inv.rs = 5'd17; inv.rt = 5'd18; inv.rd = 5'd19; inv.rsd = 32'hA5A5_A5A5; inv.pc4 = 32'h0000_2000;
    ones = '1;
    post = '0;
    post.valid = 1'b1; post.rs = 5'd1; post.rt = 5'd2; post.rd = 5'd31;
    post.rtd = 32'h8000_0001; post.mw = 1'b1; post.op = 4'hF;

    // Reset is asynchronous: outputs are zero before any clock edge
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_in = ones;
    #2;
    check_vec("reset_async_init", ex_out, z);
    @(posedge clk); #1;
    check_vec("reset_holds_over_edge", ex_out, z);
`ifdef PERF_CNT_EN
    check_cnt("reset_bcnt", bubble_cnt, 32'd0);
    check_cnt("reset_fcnt", flush_cnt, 32'd0);
`endif
    @(negedge clk); reset = 1'b0;

    step("pass_through", 1'b0, 1'b0, pt);
    step("load_capture", 1'b0, 1'b0, ld);
    step("load_use_bubble", 1'b1, 1'b0, other);
    step("stall2_a", 1'b1, 1'b0, other);
    step("stall2_b", 1'b1, 1'b0, other);
    step("resume", 1'b0, 1'b0, other);
    step("flush_only", 1'b0, 1'b1, pt);
    step("stall_and_flush", 1'b1, 1'b1, pt);
    step("invalid_passthru", 1'b0, 1'b0, inv);
    step("all_ones", 1'b0, 1'b0, ones);
    step("pass_again", 1'b0, 1'b0, pt);

    // Async reset pulse between edges while EXRegWrite=1
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_vec("midcycle_reset", ex_out, z);
    check_cnt("midcycle_reset_rw", {31'd0, ex_out.rw}, 32'd0);
`ifdef PERF_CNT_EN
    check_cnt("midcycle_reset_bcnt", bubble_cnt, 32'd0);
    check_cnt("midcycle_reset_fcnt", flush_cnt, 32'd0);
`endif
    #1;
    reset = 1'b0;
    bc_exp = 0;
    fc_exp = 0;
    step("post_reset_capture", 1'b0, 1'b0, post);

    // Reset arriving while a stall is pending discards the bubble
    step("prestall", 1'b0, 1'b0, pt);
    @(negedge clk);
    stall = 1'b1;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check_vec("reset_over_stall", ex_out, z);
    @(negedge clk);
    reset = 1'b0;
    step("after_stall_reset", 1'b0, 1'b0, other);

`ifdef PERF_CNT_EN
    @(posedge clk); #2;
    force dut.bubble_cnt_p1 = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_p1;
    bc_exp = 32'hFFFF_FFFE;
    step("sat_1", 1'b1, 1'b0, pt);
    step("sat_2", 1'b1, 1'b0, pt);
    step("sat_3", 1'b1, 1'b0, pt);
`endif

    step("final_idle", 1'b0, 1'b0, z);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
